// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks a and b DIGIT bits per cycle, MSB digit first, stopping at the first difference.
// Optional feature macro SIGNED_CMP_EN adds the signed_op port for two's-complement ordering.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
`ifdef SIGNED_CMP_EN
    input  logic                         signed_op,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         gt,
    output logic                         lt,
    output logic                         eq,
    output logic [$clog2(WIDTH/DIGIT):0] digits
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0] load_a, load_b;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] da, db;
    logic [1:0]       ord;
    logic             last;
    logic             decide;
    logic             accept;

    // {greater, less} for one digit pair; both zero means equal
    function automatic logic [1:0] digit_cmp(input logic [DIGIT-1:0] x, input logic [DIGIT-1:0] y);
        return {x > y, x < y};
    endfunction

`ifdef SIGNED_CMP_EN
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order
    assign load_a = signed_op ? (a ^ MSB) : a;
    assign load_b = signed_op ? (b ^ MSB) : b;
`else
    assign load_a = a;
    assign load_b = b;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign da        = sa[WIDTH-1 -: DIGIT];
    assign db        = sb[WIDTH-1 -: DIGIT];
    assign ord       = digit_cmp(da, db);
    assign last      = (cnt == CW'(N - 1));
    assign decide    = (ord != 2'b00) || last;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (decide)    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            digits <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
                if (decide) begin
                    gt     <= ord[1];
                    lt     <= ord[0];
                    eq     <= (ord == 2'b00);
                    digits <= cnt + CW'(1);
                end
            end
        end
    end

    // Operand shift registers carry no reset; they are only read in RUN
    always_ff @(posedge clk) begin
        if (accept) begin
            sa <= load_a;
            sb <= load_b;
        end else if (state == RUN) begin
            sa <= sa << DIGIT;
            sb <= sb << DIGIT;
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: default 32/2 instance plus a 2-bit single-digit instance.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sop = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        gt, lt, eq;
    logic [4:0]  digits;

    logic        c_in_valid = 1'b0;
    logic        c_in_ready;
    logic [1:0]  c_a = '0;
    logic [1:0]  c_b = '0;
    logic        c_sop = 1'b0;
    logic        c_out_valid;
    logic        c_out_ready = 1'b0;
    logic        c_gt, c_lt, c_eq;
    logic [0:0]  c_digits;

    int n_asserts = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SIGNED_CMP_EN
        .signed_op (sop),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .digits    (digits)
    );

    seq_magnitude_comparator #(.WIDTH(2), .DIGIT(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .a         (c_a),
        .b         (c_b),
`ifdef SIGNED_CMP_EN
        .signed_op (c_sop),
`endif
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .gt        (c_gt),
        .lt        (c_lt),
        .eq        (c_eq),
        .digits    (c_digits)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one compare from IDLE, measure latency, optionally stall the result, then retire it.
    task automatic do_cmp(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic s, input int hold,
                          input logic eg, input logic el, input logic ee, input int ed);
        int lat;
        chk({tag, ".in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        a = ta; b = tb_v; sop = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb_v; sop = ~s;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, ed);
        chk({tag, ".flags"}, {29'b0, gt, lt, eq}, {29'b0, eg, el, ee});
        chk({tag, ".digits"}, {27'b0, digits}, ed);
        chk({tag, ".in_ready_done"}, {31'b0, in_ready}, 32'd0);
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            chk({tag, ".held_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, ".held_flags"}, {29'b0, gt, lt, eq}, {29'b0, eg, el, ee});
            chk({tag, ".held_digits"}, {27'b0, digits}, ed);
            chk({tag, ".held_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".retired"}, {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          ed;
        logic [3:0]  v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ctrl", {30'b0, in_ready, out_valid}, 32'h2);
        chk("reset.flags", {24'b0, gt, lt, eq, digits}, 32'h0);
        chk("reset.dut2", {29'b0, c_in_ready, c_out_valid, c_gt}, 32'h4);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_cmp("t2_gt", 32'hC000_0000, 32'h8000_0000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1);
        do_cmp("t3_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b0, 1'b1, 16);
        do_cmp("t4_lt", 32'h0000_0001, 32'h0000_0002, 1'b0, 5, 1'b0, 1'b1, 1'b0, 16);

        // Reset held two cycles while a compare is mid-RUN
        a = 32'hAAAA_AAAA; b = 32'hAAAA_AAAA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("t1.running", {30'b0, in_ready, out_valid}, 32'h0);
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t1.ctrl", {30'b0, in_ready, out_valid}, 32'h2);
        chk("t1.flags", {24'b0, gt, lt, eq, digits}, 32'h0);
        repeat (20) begin @(posedge clk); #1; end
        chk("t1.stays_idle", {30'b0, in_ready, out_valid}, 32'h2);

`ifdef SIGNED_CMP_EN
        do_cmp("t5_signed", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1);
        do_cmp("t5_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1);
        do_cmp("t5_signed_deep", 32'h8000_0001, 32'h8000_0002, 1'b1, 1, 1'b0, 1'b1, 1'b0, 16);
`endif

        // Back-to-back pseudo-random pairs against a first-differing-digit model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 3)
                0:       rb = $urandom;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = ra;
            endcase
            ed = 16;
            for (int d = 0; d < 16; d++) begin
                if (((ra ^ rb) >> (30 - 2 * d)) & 32'h3) begin
                    ed = d + 1;
                    break;
                end
            end
            do_cmp($sformatf("rnd%0d", i), ra, rb, 1'b0, $urandom_range(0, 3),
                   ra > rb, ra < rb, ra == rb, ed);
        end

        // Exhaustive single-digit sweep on the 2-bit instance
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            c_a = v[3:2]; c_b = v[1:0]; c_in_valid = 1'b1;
            @(posedge clk); #1;
            c_in_valid = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("sweep%0d.valid", i), {30'b0, c_out_valid, c_digits}, 32'h3);
            chk($sformatf("sweep%0d.flags", i), {29'b0, c_gt, c_lt, c_eq},
                {29'b0, v[3:2] > v[1:0], v[3:2] < v[1:0], v[3:2] == v[1:0]});
            c_out_ready = 1'b1;
            @(posedge clk); #1;
            c_out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
